// File: rtl/bram_burst_loader.sv
// ---------------------------------------------------------------------------
// bram_burst_loader
//
// Reads a burst of consecutive words out of a registered-output block RAM and
// streams them to a valid/ready consumer through a small buffer. Reads are
// only issued when the buffer is guaranteed to have room for the returning
// word, so a stalled consumer never causes data loss.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : asynchronous, active-high reset
//   start      : one-cycle burst request (ignored while busy)
//   base_addr  : first word address of the burst
//   length     : number of words in the burst, 0..DEPTH
//   busy       : burst in progress
//   done       : one-cycle completion pulse
//   mem_addr   : read address to the memory
//   mem_re     : read enable to the memory
//   mem_data   : memory read data, valid one edge after the mem_re edge
//   out_valid  : a beat is available
//   out_ready  : consumer accepts the beat
//   out_data   : beat payload
//   out_last   : final beat of the burst
// ---------------------------------------------------------------------------
module bram_burst_loader #(
    parameter int  DATA_WIDTH = 128,
    parameter int  DEPTH      = 256,
    parameter int  FIFO_DEPTH = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           length,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int            PW         = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [PW+1:0] FIFO_SLOTS = (PW+2)'(FIFO_DEPTH);
    localparam logic [AW:0]   ONE_LEFT   = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [AW:0]             remain_q, remain_d;
    logic                    inflight_q, inflight_d;
    logic                    inflightLast_q, inflightLast_d;
    logic                    done_q, done_d;
    logic [PW-1:0]           wrPtr_q, wrPtr_d;
    logic [PW-1:0]           rdPtr_q, rdPtr_d;
    logic [PW:0]             count_q, count_d;
    logic [DATA_WIDTH-1:0]   fifoData_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifoLast_q;

    logic                    fifoValid;
    logic                    push;
    logic                    pop;
    logic                    headLast;
    logic                    canIssue;
    logic                    memRe;
    logic [PW+1:0]           occupancy;

    assign fifoValid = (count_q != '0);
    assign headLast  = fifoLast_q[rdPtr_q];
    assign push      = inflight_q;
    assign pop       = fifoValid && out_ready;

    // A read already in flight has a reserved slot, so it counts as occupied.
    // Pops in the current cycle are deliberately not credited, keeping the
    // issue decision independent of out_ready.
    assign occupancy = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q};
    assign canIssue  = (occupancy < FIFO_SLOTS);

    // Burst sequencing: latch the request, issue reads while there is room,
    // then wait for the final beat to leave the buffer.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remain_d       = remain_q;
        inflight_d     = 1'b0;
        inflightLast_d = inflightLast_q;
        done_d         = 1'b0;
        memRe          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = length;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (canIssue) begin
                    memRe          = 1'b1;
                    inflight_d     = 1'b1;
                    inflightLast_d = (remain_q == ONE_LEFT);
                    remain_d       = remain_q - 1'b1;
                    addr_d         = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    if (remain_q == ONE_LEFT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && headLast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Buffer pointer and occupancy bookkeeping; push and pop together leave
    // the count unchanged.
    always_comb begin
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset abandons any burst, including the word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            remain_q       <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            done_q         <= 1'b0;
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remain_q       <= remain_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
            done_q         <= done_d;
            wrPtr_q        <= wrPtr_d;
            rdPtr_q        <= rdPtr_d;
            count_q        <= count_d;
        end
    end

    // Buffer storage needs no reset: entries are only observed while the
    // occupancy count says they hold valid data.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoData_q[wrPtr_q] <= mem_data;
            fifoLast_q[wrPtr_q] <= inflightLast_q;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_re    = memRe;
    assign out_valid = fifoValid;
    assign out_data  = fifoValid ? fifoData_q[rdPtr_q] : '0;
    assign out_last  = fifoValid && headLast;

endmodule

// File: tb/tb_bram_burst_loader.sv
// ---------------------------------------------------------------------------
// tb_bram_burst_loader
//
// Self-checking bench for bram_burst_loader. The memory holds word n as the
// 32-bit lanes {4n+1, 4n+2, 4n+3, 4n+4}. The expected beat stream of a burst
// is simply the list of words base, base+1, ... modulo DEPTH, with the last
// flag on the final one; every accepted beat is checked against that list.
// ---------------------------------------------------------------------------
module tb_bram_burst_loader;

    localparam int DATA_WIDTH = 128;
    localparam int DEPTH      = 256;
    localparam int FIFO_DEPTH = 4;
    localparam int AW         = 8;

    typedef struct {
        int          base;
        int          len;
        int          readyPct;
        int          stall;
        int          restartAt;
        logic [31:0] firstLane;
        logic [31:0] lastLane;
    } burstVec_t;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [AW-1:0]         base_addr;
    logic [AW:0]           length;
    logic                  busy;
    logic                  done;
    logic [AW-1:0]         mem_addr;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    logic [DATA_WIDTH-1:0] memArray [DEPTH];

    int total = 0;
    int bad   = 0;

    logic [DATA_WIDTH-1:0] expData [$];
    logic                  expLast [$];
    int                    addrSeen [$];
    int                    reCount;
    int                    doneSeen;
    int                    beatsSeen;
    logic [DATA_WIDTH-1:0] firstBeat;
    logic [DATA_WIDTH-1:0] lastBeat;

    bram_burst_loader #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_data (mem_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output block RAM model.
    always @(posedge clk) begin
        if (mem_re) mem_data <= memArray[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input int base, input int len);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
    endtask

    // Observe one cycle at the falling edge (scoreboard accepted beats, count
    // reads and done pulses), then advance to just after the next rising edge.
    task automatic sampleCycle();
        @(negedge clk);
        if (mem_re) begin
            reCount++;
            addrSeen.push_back(int'(mem_addr));
        end
        if (done) doneSeen++;
        if (out_valid && out_ready) begin
            if (beatsSeen == 0) firstBeat = out_data;
            lastBeat = out_data;
            beatsSeen++;
            if (expData.size() == 0) begin
                checkOutput("unexpected beat", out_data, '0);
            end else begin
                checkOutput("beat data", out_data, expData.pop_front());
                checkOutput("beat last", {127'b0, out_last}, {127'b0, expLast.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clearScoreboard();
        expData.delete();
        expLast.delete();
        addrSeen.delete();
        reCount   = 0;
        doneSeen  = 0;
        beatsSeen = 0;
        firstBeat = '0;
        lastBeat  = '0;
    endtask

    task automatic runBurst(input burstVec_t v, input bit checkLanes);
        int  cyc;
        bit  addrOk;
        clearScoreboard();
        for (int i = 0; i < v.len; i++) begin
            expData.push_back(memArray[(v.base + i) % DEPTH]);
            expLast.push_back(i == v.len - 1);
        end
        applyStimulus(v.base, v.len);
        out_ready = (v.stall == 0);
        sampleCycle();
        start = 1'b0;
        cyc = 0;
        while (doneSeen == 0 && cyc < 5000) begin
            if (v.restartAt >= 0 && cyc == v.restartAt) applyStimulus(9, 3);
            else start = 1'b0;
            if (cyc < v.stall) out_ready = 1'b0;
            else out_ready = ($urandom_range(99) < v.readyPct);
            sampleCycle();
            cyc++;
            if (cyc <= v.stall && out_valid)
                checkOutput("stall head", out_data, memArray[v.base % DEPTH]);
            if (v.stall > 0 && cyc == v.stall)
                checkOutput("stall read bound", {127'b0, reCount <= FIFO_DEPTH}, 128'd1);
        end
        start = 1'b0;
        checkOutput("done timeout", {127'b0, doneSeen > 0}, 128'd1);
        out_ready = 1'b1;
        repeat (4) sampleCycle();
        checkOutput("done count", 128'(doneSeen), 128'd1);
        checkOutput("beats left", 128'(expData.size()), 128'd0);
        checkOutput("beat count", 128'(beatsSeen), 128'(v.len));
        checkOutput("read count", 128'(reCount), 128'(v.len));
        addrOk = (addrSeen.size() == v.len);
        foreach (addrSeen[i]) if (addrSeen[i] != (v.base + i) % DEPTH) addrOk = 1'b0;
        checkOutput("addr order", {127'b0, addrOk}, 128'd1);
        checkOutput("idle after", {127'b0, busy}, 128'd0);
        if (checkLanes) begin
            checkOutput("first lane", 128'(firstBeat[127:96]), 128'(v.firstLane));
            checkOutput("last lane", 128'(lastBeat[127:96]), 128'(v.lastLane));
        end
    endtask

    initial begin
        burstVec_t vecs [7];
        logic [4:0] seqA [8];
        logic [4:0] seqZ [4];
        burstVec_t  rv;

        for (int i = 0; i < DEPTH; i++)
            memArray[i] = {32'(4*i+1), 32'(4*i+2), 32'(4*i+3), 32'(4*i+4)};

        vecs[0] = '{base: 2,   len: 3,   readyPct: 100, stall: 0,  restartAt: -1, firstLane: 32'h9,   lastLane: 32'h11};
        vecs[1] = '{base: 254, len: 4,   readyPct: 100, stall: 0,  restartAt: -1, firstLane: 32'h3F9, lastLane: 32'h5};
        vecs[2] = '{base: 0,   len: 8,   readyPct: 100, stall: 10, restartAt: -1, firstLane: 32'h1,   lastLane: 32'h1D};
        vecs[3] = '{base: 2,   len: 6,   readyPct: 100, stall: 0,  restartAt: 2,  firstLane: 32'h9,   lastLane: 32'h1D};
        vecs[4] = '{base: 100, len: 1,   readyPct: 30,  stall: 0,  restartAt: -1, firstLane: 32'h191, lastLane: 32'h191};
        vecs[5] = '{base: 250, len: 10,  readyPct: 60,  stall: 0,  restartAt: -1, firstLane: 32'h3E9, lastLane: 32'hD};
        vecs[6] = '{base: 0,   len: 256, readyPct: 100, stall: 0,  restartAt: -1, firstLane: 32'h1,   lastLane: 32'h3FD};

        // {busy, mem_re, out_valid, out_last, done} per cycle from the start cycle.
        seqA = '{5'b00000, 5'b11000, 5'b11000, 5'b11100, 5'b10100, 5'b10110, 5'b00001, 5'b00000};
        seqZ = '{5'b00000, 5'b00001, 5'b00000, 5'b00000};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        clearScoreboard();
        #1;
        checkOutput("reset ctrl", {123'b0, busy, done, mem_re, out_valid, out_last}, 128'd0);
        checkOutput("reset addr", 128'(mem_addr), 128'd0);
        checkOutput("reset data", out_data, 128'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Exact cycle timing of a short burst with the consumer always ready.
        out_ready = 1'b1;
        applyStimulus(2, 3);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("timing c%0d", c), {123'b0, busy, mem_re, out_valid, out_last, done}, {123'b0, seqA[c]});
            if (c >= 3 && c <= 5) checkOutput($sformatf("timing data c%0d", c), out_data, memArray[c - 1]);
            @(posedge clk); #1;
            start = 1'b0;
        end

        // Zero-length request completes without touching memory.
        applyStimulus(17, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("zero len c%0d", c), {123'b0, busy, mem_re, out_valid, out_last, done}, {123'b0, seqZ[c]});
            @(posedge clk); #1;
            start = 1'b0;
        end

        for (int i = 0; i < 7; i++) runBurst(vecs[i], 1'b1);

        // Reset in the middle of a burst with data buffered and in flight.
        clearScoreboard();
        for (int i = 0; i < 8; i++) begin
            expData.push_back(memArray[i]);
            expLast.push_back(i == 7);
        end
        out_ready = 1'b1;
        applyStimulus(0, 8);
        sampleCycle();
        start = 1'b0;
        sampleCycle();
        sampleCycle();
        rst = 1'b1;
        #1;
        checkOutput("abort ctrl", {123'b0, busy, done, mem_re, out_valid, out_last}, 128'd0);
        checkOutput("abort addr", 128'(mem_addr), 128'd0);
        checkOutput("abort data", out_data, 128'd0);
        expData.delete();
        expLast.delete();
        sampleCycle();
        sampleCycle();
        rst = 1'b0;
        clearScoreboard();
        repeat (6) sampleCycle();
        checkOutput("stale done", 128'(doneSeen), 128'd0);
        checkOutput("stale beats", 128'(beatsSeen), 128'd0);
        checkOutput("stale reads", 128'(reCount), 128'd0);
        rv = '{base: 5, len: 1, readyPct: 100, stall: 0, restartAt: -1, firstLane: 32'h15, lastLane: 32'h15};
        runBurst(rv, 1'b1);

        // Randomized bursts against the word-list model.
        for (int i = 0; i < 6; i++) begin
            rv.base      = int'($urandom_range(DEPTH - 1));
            rv.len       = int'($urandom_range(40, 1));
            rv.readyPct  = int'($urandom_range(100, 20));
            rv.stall     = 0;
            rv.restartAt = -1;
            rv.firstLane = '0;
            rv.lastLane  = '0;
            runBurst(rv, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
